instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the processor's decode/execute datapath. Owns the program counter, issues sequential reads to the synchronous instruction memory, and buffers returned 16-bit instructions with their PCs in a small FIFO. Presents them to the downstream stage over a valid/ready handshake. Accepts branch/jump redirects from execute, flushing all queued and in-flight fetches.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_fifo.sv | 69 ++++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ============================================================================
// Module      : ifu_pkg
// Description : Shared opcodes, default widths and FIFO entry type for the IFU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

  localparam logic [3:0] OP_J   = 4'b0010;
  localparam logic [3:0] OP_BEQ = 4'b1000;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module      : ifu_fifo
// Description : DEPTH-entry first-word-fall-through FIFO of fetch entries with
//               synchronous clear and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count
);

  localparam logic [AW-1:0] c_ptr_one = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   c_cnt_one = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Clear dominates both push and pop; a pop of an empty FIFO is ignored.
  assign w_do_push = i_push && !i_clear;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and credit-based prefetcher feeding decode through a
//               FWFT FIFO. Optional J-predecode enabled by IFU_JPREDECODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     c_depth   = (CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] c_pc_one  = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_drop;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_pending;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic            w_drop_nxt;

  // Outstanding credit covers both queued entries and the request in flight,
  // so the response slot is always guaranteed when data returns.
  assign w_pending = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign imem_req  = rst_n && !redirect_valid && (w_pending < c_depth);
  assign imem_addr = r_fetch_pc;

  assign w_push             = r_inflight && !r_drop;
  assign w_pop              = instr_valid && instr_ready;
  assign w_push_entry.pc    = r_req_pc;
  assign w_push_entry.instr = imem_rdata;

`ifdef IFU_JPREDECODE_EN
  logic w_jtaken;
  assign w_jtaken = w_push && !redirect_valid && (imem_rdata[INSTR_W-1 -: 4] == OP_J);
`endif

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_drop_nxt     = 1'b0;
    if (redirect_valid) begin
      w_fetch_pc_nxt = redirect_pc;
      w_drop_nxt     = 1'b1;
`ifdef IFU_JPREDECODE_EN
    end else if (w_jtaken) begin
      // Request issued alongside the J is on the wrong path; drop its data.
      w_fetch_pc_nxt = PC_W'(imem_rdata[7:0]);
      w_drop_nxt     = 1'b1;
`endif
    end else if (imem_req) begin
      w_fetch_pc_nxt = r_fetch_pc + c_pc_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_inflight <= imem_req;
      r_drop     <= w_drop_nxt;
      if (imem_req) r_req_pc <= r_fetch_pc;
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Head fields are masked while empty so stale storage never leaks out.
  assign instr_valid = (w_count != '0);
  assign instr       = instr_valid ? w_head.instr : '0;
  assign instr_pc    = instr_valid ? w_head.pc    : '0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  instr_fetch_unit #(
    .PC_W     (8),
    .INSTR_W  (16),
    .DEPTH    (4),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  typedef struct packed {
    logic        ready;
    logic        rv;
    logic [7:0]  rpc;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [7:0] rpc);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_head(input string name, input logic [7:0] pc, input logic [15:0] ins);
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk({name, "_pc"},    32'(instr_pc),    32'(pc));
    chk({name, "_instr"}, 32'(instr),       32'(ins));
  endtask

  initial begin
    logic [7:0]  acc_pc [16];
    logic [15:0] acc_in [16];
    int          n_acc;

    for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
    imem_rdata     = 16'h0000;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;

    // Stream, back-pressure fill/resume, then redirect to 0x40.
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 16'h0000, 8'h00};
    vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 16'h1000, 8'h00};
    vt[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 16'h1001, 8'h01};
    vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 16'h1002, 8'h02};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 16'h1003, 8'h03};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 16'h1003, 8'h03};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 16'h1003, 8'h03};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 16'h1003, 8'h03};
    vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 16'h1004, 8'h04};
    vt[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 16'h1005, 8'h05};
    vt[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h09, 1'b1, 16'h1006, 8'h06};
    vt[12] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h0A, 1'b1, 16'h1007, 8'h07};
    vt[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 16'h0000, 8'h00};
    vt[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 16'h0000, 8'h00};
    vt[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 16'h1040, 8'h40};

    // Reset state
    #1;
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  32'(imem_addr),   32'h00);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr),       32'h0000);
    chk("rst_pc",    32'(instr_pc),    32'h00);

    // Table-driven stream
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].ready, vt[i].rv, vt[i].rpc);
      chk($sformatf("vec%0d_req", i),   32'(imem_req),    32'(vt[i].e_req));
      chk($sformatf("vec%0d_addr", i),  32'(imem_addr),   32'(vt[i].e_addr));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_instr", i), 32'(instr),    32'(vt[i].e_instr));
        chk($sformatf("vec%0d_pc", i),    32'(instr_pc), 32'(vt[i].e_pc));
      end
      @(negedge clk);
    end

    // Redirect with three queued entries and one fetch in flight
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 8'h40);
    chk("redir_req_blocked", 32'(imem_req), 32'd0);
    chk_head("redir_before", 8'h00, 16'h1000);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    chk("redir_r1_valid", 32'(instr_valid), 32'd0);
    chk("redir_r1_req",   32'(imem_req),    32'd1);
    chk("redir_r1_addr",  32'(imem_addr),   32'h40);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk("redir_r2_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk_head("redir_r3", 8'h40, 16'h1040);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk_head("redir_r4", 8'h41, 16'h1041);
    @(negedge clk);

    // PC wrap from 0xFE
    do_reset();
    drive(1'b1, 1'b1, 8'hFE);
    chk("wrap_c0_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk("wrap_c1_addr", 32'(imem_addr), 32'hFE);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk("wrap_c2_addr", 32'(imem_addr), 32'hFF);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk("wrap_c3_addr", 32'(imem_addr), 32'h00);
    chk_head("wrap_c3", 8'hFE, 16'h10FE);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk_head("wrap_c4", 8'hFF, 16'h10FF);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk_head("wrap_c5", 8'h00, 16'h1000);
    @(negedge clk);

    // J at word 5
    mem[5] = 16'h2020;
    do_reset();
    n_acc = 0;
    for (int c = 0; c < 24 && n_acc < 16; c++) begin
      drive(1'b1, 1'b0, 8'h00);
      if (instr_valid) begin
        acc_pc[n_acc] = instr_pc;
        acc_in[n_acc] = instr;
        n_acc++;
      end
      @(negedge clk);
    end
    chk("j_enough_accepts", 32'(n_acc >= 7), 32'd1);
    if (n_acc >= 7) begin
      chk("j_pc4",    32'(acc_pc[4]), 32'h04);
      chk("j_pc5",    32'(acc_pc[5]), 32'h05);
      chk("j_instr5", 32'(acc_in[5]), 32'h2020);
`ifdef IFU_JPREDECODE_EN
      chk("j_next_pc", 32'(acc_pc[6]), 32'h20);
      chk("j_next_in", 32'(acc_in[6]), 32'h1020);
`else
      chk("j_next_pc", 32'(acc_pc[6]), 32'h06);
      chk("j_next_in", 32'(acc_in[6]), 32'h1006);
`endif
    end
    mem[5] = 16'h1005;

    // Asynchronous reset with a full FIFO
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("full_req", 32'(imem_req), 32'd0);
    chk_head("full_head", 8'h00, 16'h1000);
    rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req),    32'd0);
    chk("arst_addr",  32'(imem_addr),   32'h00);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instr),       32'h0000);
    chk("arst_pc",    32'(instr_pc),    32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    chk("restart_c0_req",  32'(imem_req),  32'd1);
    chk("restart_c0_addr", 32'(imem_addr), 32'h00);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk("restart_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    chk_head("restart_c2", 8'h00, 16'h1000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
